// File: rtl/top.sv
// Multicycle 16-bit accumulator processor running a fixed 16x8 ROM program,
// with a time-multiplexed 4-digit hex display of the accumulator.
module top #(
   parameter int REFRESH_BITS = 17
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] anode,
   output logic [7:0] catode,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_WB     = 4'd3,
      S_BRANCH = 4'd4,
      S_HALT   = 4'd5
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUBI = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_JMP  = 3'b101;
   localparam logic [2:0] OP_JNZ  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   state_t                  state_q, state_d;
   logic [3:0]              pc_q, pc_d;
   logic [7:0]              ir_q, ir_d;
   logic [15:0]             acc_q, acc_d;
   logic [15:0]             res_q, res_d;
   logic [REFRESH_BITS-1:0] refresh_q;
   logic [2:0]              op;
   logic [15:0]             imm;
   logic [1:0]              sel;
   logic [3:0]              digit;

   function automatic logic [7:0] rom(input logic [3:0] addr);
      case (addr)
         4'd0:    rom = 8'h25;
         4'd1:    rom = 8'h43;
         4'd2:    rom = 8'h80;
         4'd3:    rom = 8'h61;
         4'd4:    rom = 8'hE0;
         default: rom = 8'h00;
      endcase
   endfunction

   // All arithmetic wraps naturally at 16 bits.
   function automatic logic [15:0] alu(input logic [2:0] f, input logic [15:0] a,
                                       input logic [15:0] b);
      case (f)
         OP_LDI:  alu = b;
         OP_ADDI: alu = a + b;
         OP_SUBI: alu = a - b;
         OP_SHL:  alu = {a[14:0], 1'b0};
         default: alu = a;
      endcase
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 8'hC0;
         4'h1: seg7 = 8'hF9;
         4'h2: seg7 = 8'hA4;
         4'h3: seg7 = 8'hB0;
         4'h4: seg7 = 8'h99;
         4'h5: seg7 = 8'h92;
         4'h6: seg7 = 8'h82;
         4'h7: seg7 = 8'hF8;
         4'h8: seg7 = 8'h80;
         4'h9: seg7 = 8'h90;
         4'hA: seg7 = 8'h88;
         4'hB: seg7 = 8'h83;
         4'hC: seg7 = 8'hC6;
         4'hD: seg7 = 8'hA1;
         4'hE: seg7 = 8'h86;
         default: seg7 = 8'h8E;
      endcase
   endfunction

   assign op  = ir_q[7:5];
   assign imm = {11'd0, ir_q[4:0]};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      res_d   = res_q;
      case (state_q)
         S_FETCH: begin
            ir_d    = rom(pc_q);
            pc_d    = pc_q + 4'd1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (op)
               OP_NOP:         state_d = S_FETCH;
               OP_JMP, OP_JNZ: state_d = S_BRANCH;
               OP_HALT:        state_d = S_HALT;
               default:        state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            res_d   = alu(op, acc_q, imm);
            state_d = S_WB;
         end
         S_WB: begin
            acc_d   = res_q;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            if (op == OP_JMP || acc_q != 16'd0) pc_d = ir_q[3:0];
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         // Codes 6-15 are unreachable in normal operation; recover to FETCH.
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         pc_q      <= 4'd0;
         ir_q      <= 8'd0;
         acc_q     <= 16'd0;
         res_q     <= 16'd0;
         refresh_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
         refresh_q <= refresh_q + REFRESH_BITS'(1);
      end
   end

   assign sel   = refresh_q[REFRESH_BITS-1 -: 2];
   assign state = state_q;

   always_comb begin
      anode = 4'b1110;
      digit = acc_q[3:0];
      case (sel)
         2'd1: begin anode = 4'b1101; digit = acc_q[7:4];   end
         2'd2: begin anode = 4'b1011; digit = acc_q[11:8];  end
         2'd3: begin anode = 4'b0111; digit = acc_q[15:12]; end
         default: ;
      endcase
      catode = seg7(digit);
   end

endmodule

// File: tb/tb_top.sv
// Directed bench for the accumulator processor: program trace, HALT hold,
// display scan and asynchronous mid-program reset.
`timescale 1ns/100ps
module tb_top;

   logic       clk;
   logic       reset;
   logic [3:0] anode;
   logic [7:0] catode;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;
   int edges = 0;

   typedef struct {
      logic [3:0]  st;
      logic [15:0] acc;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [7:0] ca;
   } disp_t;

   vec_t  tbl[18];
   disp_t scan[4];

   top #(.REFRESH_BITS(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .anode  (anode),
      .catode (catode),
      .state  (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edges);
      end
   endtask

   function automatic logic [7:0] seg_exp(input logic [3:0] d);
      logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return t[d];
   endfunction

   // Refresh counter equals edges-since-release mod 16 with REFRESH_BITS=4.
   task automatic chk_disp(input logic [15:0] acc);
      int         sel;
      logic [3:0] d;
      logic [3:0] an;
      sel = (edges % 16) / 4;
      d   = 4'((acc >> (4 * sel)) & 16'hF);
      an  = ~(4'b0001 << sel);
      chk("anode", 32'(anode), 32'(an));
      chk("catode", 32'(catode), 32'(seg_exp(d)));
   endtask

   task automatic step_chk(input logic [3:0] st, input logic [15:0] acc);
      @(posedge clk);
      edges++;
      #1;
      chk("state", 32'(state), 32'(st));
      chk("acc", 32'(dut.acc_q), 32'(acc));
      chk_disp(acc);
   endtask

   task automatic run_program(input int n);
      for (int i = 0; i < n; i++) step_chk(tbl[i].st, tbl[i].acc);
   endtask

   task automatic hold_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_anode", 32'(anode), 32'he);
      chk("rst_catode", 32'(catode), 32'hc0);
      @(posedge clk);
      #1;
      chk("rst_hold_state", 32'(state), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      edges = 0;
   endtask

   initial begin
      tbl = '{
         '{4'd1, 16'h0000}, '{4'd2, 16'h0000}, '{4'd3, 16'h0000}, '{4'd0, 16'h0005},
         '{4'd1, 16'h0005}, '{4'd2, 16'h0005}, '{4'd3, 16'h0005}, '{4'd0, 16'h0008},
         '{4'd1, 16'h0008}, '{4'd2, 16'h0008}, '{4'd3, 16'h0008}, '{4'd0, 16'h0010},
         '{4'd1, 16'h0010}, '{4'd2, 16'h0010}, '{4'd3, 16'h0010}, '{4'd0, 16'h000F},
         '{4'd1, 16'h000F}, '{4'd5, 16'h000F}
      };
      scan = '{'{4'b1110, 8'h8E}, '{4'b1101, 8'hC0}, '{4'b1011, 8'hC0}, '{4'b0111, 8'hC0}};

      reset = 1'b0;
      #12;
      chk("init_state", 32'(state), 32'h0);
      chk("init_anode", 32'(anode), 32'he);
      chk("init_catode", 32'(catode), 32'hc0);
      hold_reset();

      run_program(18);

      // HALT must hold state and ACC indefinitely while the display scans.
      for (int i = 0; i < 110; i++) step_chk(4'd5, 16'h000F);

      // Align to a refresh wrap, then sample one digit slot every 4 clocks.
      for (int i = 0; i < 16 && (edges % 16) != 0; i++) begin
         @(posedge clk);
         edges++;
      end
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("scan_anode", 32'(anode), 32'(scan[k].an));
         chk("scan_catode", 32'(catode), 32'(scan[k].ca));
         repeat (4) begin
            @(posedge clk);
            edges++;
         end
      end

      // Fresh run, then asynchronous reset pulse just after edge 10.
      hold_reset();
      run_program(10);
      reset = 1'b0;
      #0.5;
      chk("async_state", 32'(state), 32'h0);
      chk("async_acc", 32'(dut.acc_q), 32'h0);
      chk("async_anode", 32'(anode), 32'he);
      chk("async_catode", 32'(catode), 32'hc0);
      #0.5;
      reset = 1'b1;
      edges = 0;
      run_program(18);
      for (int i = 0; i < 8; i++) step_chk(4'd5, 16'h000F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter: REFRESH_BITS, default 17, width of the display refresh counter; the benches use 4.
REQ-002 Port: clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset.
REQ-004 Port: anode, output, 4, active-low digit enables; exactly one bit low at any time.
REQ-005 Port: catode, output, 8, active-low segments {dp,g,f,e,d,c,b,a}; dp (bit 7) is always 1.
REQ-006 Port: state, output, 4, current control-FSM state code.

Function
REQ-007 The block SHALL be a multicycle accumulator processor with a 4-bit PC, 8-bit IR, 16-bit ACC, an internal 16x8 ROM, and a 4-digit hex display of ACC.
REQ-008 Instruction format: op = IR[7:5], imm = IR[4:0], zero-extended to 16 bits.
REQ-009 Opcodes:
- 000 NOP
- 001 LDI: ACC=imm
- 010 ADDI: ACC=ACC+imm
- 011 SUBI: ACC=ACC-imm
- 100 SHL: ACC=ACC<<1
- 101 JMP: PC=imm[3:0]
- 110 JNZ: if ACC!=0 then PC=imm[3:0]
- 111 HALT
REQ-010 ALU results SHALL wrap modulo 2^16: 0-1 gives 0xFFFF; SHL discards bit 15.
REQ-011 FSM state codes: FETCH=0, DECODE=1, EXEC=2, WB=3, BRANCH=4, HALT=5; codes 6-15 are unused and SHALL go to FETCH on the next edge.
REQ-012 FETCH: IR<=ROM[PC]; PC<=PC+1 (15 wraps to 0); next state DECODE.
REQ-013 DECODE transitions: ops 001-100 go to EXEC; 101/110 go to BRANCH; 000 goes to FETCH; 111 goes to HALT.
REQ-014 EXEC: register the ALU result; next state WB.
REQ-015 WB: ACC<=registered result; next state FETCH.
REQ-016 BRANCH: update PC per REQ-009; next state FETCH.
REQ-017 HALT SHALL hold until reset; ACC, PC and IR are frozen; the display keeps running.
REQ-018 Instruction cycle counts: ALU op = 4, branch = 3, NOP = 2.
REQ-019 ROM contents (fixed): 0: 0x25 (LDI 5); 1: 0x43 (ADDI 3); 2: 0x80 (SHL); 3: 0x61 (SUBI 1); 4: 0xE0 (HALT); 5-15: 0x00.
REQ-020 Refresh counter: REFRESH_BITS wide, free-running, +1 every clock; digit select sel = top two bits of the counter.
REQ-021 Digit mapping:
- sel=0: anode=1110, shows ACC[3:0]
- sel=1: anode=1101, shows ACC[7:4]
- sel=2: anode=1011, shows ACC[11:8]
- sel=3: anode=0111, shows ACC[15:12]
REQ-022 catode encoding, digits 0-F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E (hex).
REQ-023 anode and catode SHALL be combinational from sel and the current ACC.

Reset
REQ-024 While reset=0, asynchronously: PC=0, IR=0, ACC=0, state=0 (FETCH), refresh counter=0; hence anode=1110, catode=C0.
REQ-025 Deasserting reset mid-program SHALL restart execution at ROM address 0 on the first rising edge after release.

Verification
REQ-026 Reset held low -> state=0, anode=1110, catode=C0.
REQ-027 Release reset, count rising edges -> state sequence 0,1,2,3,0; ACC=0x0005 after edge 4, 0x0008 after edge 8, 0x0010 after edge 12, 0x000F after edge 16.
REQ-028 Continue -> state=1 after edge 17, state=5 after edge 18; state stays 5 and ACC stays 0x000F for 100+ further cycles.
REQ-029 In HALT with REFRESH_BITS=4, sample every 4 clocks -> anode cycles 1110 (catode 8E), 1101 (C0), 1011 (C0), 0111 (C0).
REQ-030 Assert reset for 1 ns at edge 10 -> state=0 and ACC=0 immediately; after release, the REQ-027 timing repeats from edge 1.
